serial_exec: RTL and testbench

Bit-serial execution unit directly downstream of the instruction loader. Accepts a 4-bit opcode and 12-bit instruction word with a one-cycle start pulse. Executes the instruction LSB-first through a 1-bit ALU over 8 cycles against a 4×8-bit register file. Drives the 8-bit result shown on the LED outputs.

---
 rtl/serial_exec.sv | 215 +++++++++++++++++++++
 tb/tb_serial_exec.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_exec.sv
// serial_exec: bit-serial execution unit with a 4x8 register file.
// An accepted start latches opcode/instr, the 1-bit ALU runs LSB-first for
// 8 cycles (EXEC), then WB commits the register file, flags and out_result.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   opcode[3:0]         operation, sampled on an accepted start
//   instr[11:0]         {imm8, rs, rd}, sampled on an accepted start
//   start               one-cycle execute request (ignored while busy/err)
//   busy                instruction in flight
//   done                one-cycle pulse after commit
//   out_result[7:0]     value of the last OUT instruction
//   flag_z, flag_c      zero / carry flags (SUB/CMP: carry = no borrow)
//   err                 sticky illegal-opcode flag
// Optional feature: define SERIAL_EXEC_TRAP_EN to trap opcodes C-F.
module serial_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic [11:0] instr,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  out_result,
  output logic        flag_z,
  output logic        flag_c,
  output logic        err
);
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;
  localparam int unsigned NR = 4;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_OUT  = 4'hA;
  localparam logic [3:0] OP_CMP  = 4'hB;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [1:0]      rd_q, rd_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   res_q, res_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rf_q [NR];
  logic [DW-1:0]   rf_d [NR];
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   out_q, out_d;
  logic            z_q, z_d;
  logic            c_q, c_d;
  logic            err_q, err_d;

  logic            a_bit, b_bit, r_bit;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      rf_q    <= '{default: '0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      rf_q    <= rf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      z_q     <= z_d;
      c_q     <= c_d;
      err_q   <= err_d;
    end
  end

  // Next-state, serial ALU and writeback
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    rf_d    = rf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    out_d   = out_q;
    z_d     = z_q;
    c_d     = c_q;
    err_d   = err_q;
    a_bit   = a_q[0];
    b_bit   = b_q[0];
    r_bit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !err_q) begin
          state_d = S_EXEC;
          busy_d  = 1'b1;
          op_d    = opcode;
          rd_d    = instr[1:0];
          a_d     = rf_q[instr[1:0]];
          // Immediate forms stream imm8 through the second operand lane
          b_d     = (opcode == OP_LDI || opcode == OP_ADDI) ? instr[11:4]
                                                            : rf_q[instr[3:2]];
          carry_d = (opcode == OP_SUB || opcode == OP_CMP);
          cnt_d   = '0;
        end
      end

      S_EXEC: begin
        busy_d = 1'b1;
        case (op_q)
          OP_ADD, OP_ADDI: begin
            r_bit   = a_bit ^ b_bit ^ carry_q;
            carry_d = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
          end
          OP_SUB, OP_CMP: begin
            r_bit   = a_bit ^ ~b_bit ^ carry_q;
            carry_d = (a_bit & ~b_bit) | (a_bit & carry_q) | (~b_bit & carry_q);
          end
          OP_AND:  r_bit = a_bit & b_bit;
          OP_OR:   r_bit = a_bit | b_bit;
          OP_XOR:  r_bit = a_bit ^ b_bit;
          OP_LDI:  r_bit = b_bit;
          // SHL: carry flop delays rd by one bit; last bit out is rd[7]
          OP_SHL: begin
            r_bit   = carry_q;
            carry_d = a_bit;
          end
          // SHR: look one bit ahead; capture rd[0] on the first cycle
          OP_SHR: begin
            r_bit = a_q[1];
            if (cnt_q == '0) carry_d = a_bit;
          end
          default: r_bit = a_bit;
        endcase
        a_d   = {1'b0, a_q[DW-1:1]};
        b_d   = {1'b0, b_q[DW-1:1]};
        res_d = {r_bit, res_q[DW-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) state_d = S_WB;
      end

      S_WB: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        case (op_q)
          OP_LDI: rf_d[rd_q] = res_q;
          OP_ADD, OP_SUB, OP_ADDI, OP_SHL, OP_SHR: begin
            rf_d[rd_q] = res_q;
            z_d        = (res_q == '0);
            c_d        = carry_q;
          end
          OP_AND, OP_OR, OP_XOR: begin
            rf_d[rd_q] = res_q;
            z_d        = (res_q == '0);
            c_d        = 1'b0;
          end
          OP_CMP: begin
            z_d = (res_q == '0);
            c_d = carry_q;
          end
          OP_OUT: out_d = rf_q[rd_q];
          default: begin
`ifdef SERIAL_EXEC_TRAP_EN
            if (op_q >= 4'hC) err_d = 1'b1;
`endif
          end
        endcase
      end

      default: state_d = S_IDLE;
    endcase

`ifndef SERIAL_EXEC_TRAP_EN
    err_d = 1'b0;
`endif
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign out_result = out_q;
  assign flag_z     = z_q;
  assign flag_c     = c_q;
  assign err        = err_q;
endmodule

// File: tb/tb_serial_exec.sv
// Testbench for serial_exec: instruction-level model plus per-cycle compare,
// with literal spot checks from hand-computed results.
module tb_serial_exec;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  opcode = '0;
  logic [11:0] instr = '0;
  logic        start = 1'b0;
  logic        busy, done, flag_z, flag_c, err;
  logic [7:0]  out_result;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Instruction-level model
  logic [7:0] m_rf [4];
  logic       m_z, m_c, m_err, m_busy, m_done;
  logic [7:0] m_out;
  int         m_left;
  logic [3:0] l_op;
  logic [1:0] l_rd, l_rs;
  logic [7:0] l_imm;

  serial_exec dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr(instr), .start(start),
    .busy(busy), .done(done), .out_result(out_result),
    .flag_z(flag_z), .flag_c(flag_c), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_z = 0; m_c = 0; m_err = 0; m_out = '0; m_left = 0;
    m_busy = 0; m_done = 0;
  endtask

  task automatic model_commit();
    logic [7:0] a, b, r;
    logic [8:0] s;
    a = m_rf[l_rd];
    b = m_rf[l_rs];
    case (l_op)
      4'h1: m_rf[l_rd] = l_imm;
      4'h2: begin s = 9'(a) + 9'(b); m_rf[l_rd] = s[7:0]; m_z = (s[7:0] == 0); m_c = s[8]; end
      4'h3: begin r = a - b; m_rf[l_rd] = r; m_z = (r == 0); m_c = (a >= b); end
      4'h4: begin r = a & b; m_rf[l_rd] = r; m_z = (r == 0); m_c = 0; end
      4'h5: begin r = a | b; m_rf[l_rd] = r; m_z = (r == 0); m_c = 0; end
      4'h6: begin r = a ^ b; m_rf[l_rd] = r; m_z = (r == 0); m_c = 0; end
      4'h7: begin s = 9'(a) + 9'(l_imm); m_rf[l_rd] = s[7:0]; m_z = (s[7:0] == 0); m_c = s[8]; end
      4'h8: begin r = a << 1; m_rf[l_rd] = r; m_z = (r == 0); m_c = a[7]; end
      4'h9: begin r = a >> 1; m_rf[l_rd] = r; m_z = (r == 0); m_c = a[0]; end
      4'hA: m_out = a;
      4'hB: begin r = a - b; m_z = (r == 0); m_c = (a >= b); end
      4'hC, 4'hD, 4'hE, 4'hF: begin
`ifdef SERIAL_EXEC_TRAP_EN
        m_err = 1;
`endif
      end
      default: ;
    endcase
  endtask

  // Advance the model by the clock edge that just occurred
  task automatic model_step();
    m_done = 0;
    if (!rst_n) begin
      model_reset();
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        model_commit();
        m_done = 1;
      end
    end else if (start && !m_err) begin
      m_left = 9;
      l_op = opcode; l_rd = instr[1:0]; l_rs = instr[3:2]; l_imm = instr[11:4];
    end
    m_busy = (m_left > 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Present one instruction and wait until its done cycle (T+10)
  task automatic issue(input logic [3:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [7:0] imm);
    opcode = op; instr = {imm, rs, rd}; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 8'(busy), 8'(m_busy));
      chk("done", 8'(done), 8'(m_done));
      chk("out_result", out_result, m_out);
      chk("flag_z", 8'(flag_z), 8'(m_z));
      chk("flag_c", 8'(flag_c), 8'(m_c));
      chk("err", 8'(err), 8'(m_err));
    end
  end

  initial begin
    model_reset();
    tick();
    tick();
    chk_en = 1'b1;
    chk("reset_busy", 8'(busy), 8'h00);
    chk("reset_out", out_result, 8'h00);
    rst_n = 1'b1;
    tick();

    // LDI / OUT
    issue(4'h1, 2'd1, 2'd0, 8'h5A);
    chk("ldi_done", 8'(done), 8'h01);
    issue(4'hA, 2'd1, 2'd0, 8'h00);
    chk("out_5a", out_result, 8'h5A);
    chk("out_flags", {6'b0, flag_z, flag_c}, 8'h00);

    // ADD wrap to zero
    issue(4'h1, 2'd0, 2'd0, 8'hF0);
    issue(4'h1, 2'd1, 2'd0, 8'h10);
    issue(4'h2, 2'd0, 2'd1, 8'h00);
    issue(4'hA, 2'd0, 2'd0, 8'h00);
    chk("add_out", out_result, 8'h00);
    chk("add_flags", {6'b0, flag_z, flag_c}, 8'h03);

    // SUB with borrow, CMP equal
    issue(4'h1, 2'd2, 2'd0, 8'h03);
    issue(4'h1, 2'd3, 2'd0, 8'h05);
    issue(4'h3, 2'd2, 2'd3, 8'h00);
    chk("sub_flags", {6'b0, flag_z, flag_c}, 8'h00);
    issue(4'hA, 2'd2, 2'd0, 8'h00);
    chk("sub_out", out_result, 8'hFE);
    issue(4'hB, 2'd3, 2'd3, 8'h00);
    chk("cmp_flags", {6'b0, flag_z, flag_c}, 8'h03);
    issue(4'hA, 2'd3, 2'd0, 8'h00);
    chk("cmp_rd_kept", out_result, 8'h05);

    // Shifts
    issue(4'h1, 2'd0, 2'd0, 8'h81);
    issue(4'h8, 2'd0, 2'd0, 8'h00);
    chk("shl_c", 8'(flag_c), 8'h01);
    issue(4'hA, 2'd0, 2'd0, 8'h00);
    chk("shl_out", out_result, 8'h02);
    issue(4'h9, 2'd0, 2'd0, 8'h00);
    chk("shr_c", 8'(flag_c), 8'h00);
    issue(4'hA, 2'd0, 2'd0, 8'h00);
    chk("shr_out", out_result, 8'h01);

    // Logic ops and ADDI
    issue(4'h1, 2'd1, 2'd0, 8'hCC);
    issue(4'h1, 2'd2, 2'd0, 8'hAA);
    issue(4'h4, 2'd1, 2'd2, 8'h00);
    issue(4'hA, 2'd1, 2'd0, 8'h00);
    chk("and_out", out_result, 8'h88);
    issue(4'h5, 2'd3, 2'd0, 8'h00);
    issue(4'hA, 2'd3, 2'd0, 8'h00);
    chk("or_out", out_result, 8'h05);
    issue(4'h6, 2'd1, 2'd1, 8'h00);
    chk("xor_self_z", {6'b0, flag_z, flag_c}, 8'h02);
    issue(4'h7, 2'd2, 2'd0, 8'h56);
    chk("addi_flags", {6'b0, flag_z, flag_c}, 8'h03);

    // Start at T+4 is ignored
    opcode = 4'h1; instr = {8'h33, 2'd0, 2'd3}; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    opcode = 4'h1; instr = {8'h77, 2'd0, 2'd2}; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    issue(4'hA, 2'd2, 2'd0, 8'h00);
    chk("ignored_start", out_result, 8'h00);

    // Reset at T+5 of ADD r1,r1
    issue(4'h1, 2'd1, 2'd0, 8'h22);
    opcode = 4'h2; instr = {8'h00, 2'd1, 2'd1}; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_busy", 8'(busy), 8'h00);
    repeat (6) tick();
    chk("rst_no_done", 8'(done), 8'h00);
    issue(4'h1, 2'd2, 2'd0, 8'h11);
    issue(4'hA, 2'd1, 2'd0, 8'h00);
    chk("rst_r1", out_result, 8'h00);

    // Illegal opcode
    issue(4'hC, 2'd0, 2'd0, 8'h00);
`ifdef SERIAL_EXEC_TRAP_EN
    chk("trap_err", 8'(err), 8'h01);
    issue(4'h1, 2'd0, 2'd0, 8'h44);
    chk("trap_no_busy", 8'(busy), 8'h00);
    chk("trap_no_done", 8'(done), 8'h00);
`else
    chk("nop_err", 8'(err), 8'h00);
    chk("nop_flags", {6'b0, flag_z, flag_c}, 8'h00);
    issue(4'hA, 2'd1, 2'd0, 8'h00);
    chk("nop_out", out_result, 8'h00);
`endif
    repeat (3) tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
